// File: rtl/byteblast_pkg.sv
// Shared fetch/decode constants: word layout, opcodes and the fetch sequencer state encoding.
package byteblast_pkg;

  localparam int unsigned PC_BITS       = 5;
  localparam int unsigned INSTR_BITS    = 3;
  localparam int unsigned ADDRESS_BITS  = 5;
  localparam int unsigned VALUE_BITS    = INSTR_BITS + ADDRESS_BITS;
  localparam int unsigned SETTLE_CYCLES = 3;
  localparam int unsigned SETTLE_BITS   = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  localparam int unsigned OPC_MSB = 7;
  localparam int unsigned OPC_LSB = 5;
  localparam int unsigned OPR_MSB = 4;
  localparam int unsigned OPR_LSB = 0;

  localparam logic [INSTR_BITS-1:0] OPC_LD   = 3'b001;
  localparam logic [INSTR_BITS-1:0] OPC_ADD  = 3'b010;
  localparam logic [INSTR_BITS-1:0] OPC_STO  = 3'b100;
  localparam logic [INSTR_BITS-1:0] OPC_HALT = 3'b111;

  // Instruction word as seen on the program memory and decoder buses.
  typedef struct packed {
    logic [INSTR_BITS-1:0]   opcode;
    logic [ADDRESS_BITS-1:0] operand;
  } instr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_ISSUE,
    ST_SETTLE,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: reset to 0, increments with silent wrap at 2^PC_BITS.
module fetch_pc
  import byteblast_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [PC_BITS-1:0] pc
);

  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc) begin
      pc_d = pc_q + PC_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetch, wait for memory, issue one word, hold it while downstream settles.
// Optional BYTEBLAST_FETCH_SINGLE_STEP_EN adds a step input that runs one instruction per rising edge.
module fetch_seq
  import byteblast_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
`ifdef BYTEBLAST_FETCH_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  mem_rd,
  output logic [PC_BITS-1:0]    mem_addr,
  input  logic [VALUE_BITS-1:0] mem_data,
  input  logic                  mem_valid,
  output logic [VALUE_BITS-1:0] o_value,
  output logic                  o_enable,
  output logic [PC_BITS-1:0]    o_pc,
  output logic                  o_busy,
  output logic                  o_halted
);

  state_e                 state_q, state_d;
  logic [SETTLE_BITS-1:0] cnt_q, cnt_d;
  instr_t                 value_q, value_d;
  logic                   mem_rd_q, mem_rd_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   halted_q, halted_d;
  logic                   pc_inc;
  logic                   start;
  logic                   cont;
  logic [PC_BITS-1:0]     pc;
  instr_t                 mem_word;

  assign mem_word = mem_data;

`ifdef BYTEBLAST_FETCH_SINGLE_STEP_EN
  logic step_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // Step mode always parks in IDLE after an instruction; run re-launches from there.
  assign start = run | (step & ~step_q);
  assign cont  = 1'b0;
`else
  assign start = run;
  assign cont  = run;
`endif

  fetch_pc u_pc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pc_inc),
    .pc    (pc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    pc_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          if (mem_word.opcode == OPC_HALT) begin
            state_d = ST_HALTED;
          end else begin
            value_d = mem_word;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = SETTLE_BITS'(SETTLE_CYCLES - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          pc_inc  = 1'b1;
          state_d = cont ? ST_FETCH : ST_IDLE;
        end else begin
          cnt_d = cnt_q - SETTLE_BITS'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the state being entered.
    mem_rd_d = (state_d == ST_FETCH);
    enable_d = (state_d == ST_ISSUE);
    busy_d   = (state_d != ST_IDLE) && (state_d != ST_HALTED);
    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      value_q  <= '0;
      mem_rd_q <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      mem_rd_q <= mem_rd_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = pc;
  assign o_pc     = pc;
  assign o_value  = value_q;
  assign o_enable = enable_q;
  assign o_busy   = busy_q;
  assign o_halted = halted_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Scoreboard bench for fetch_seq: latency-programmable memory model, expected issues queued per test.
module tb_fetch_seq;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       step;
  logic       mem_rd;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_valid;
  logic [7:0] o_value;
  logic       o_enable;
  logic [4:0] o_pc;
  logic       o_busy;
  logic       o_halted;

`ifdef BYTEBLAST_FETCH_SINGLE_STEP_EN
  localparam int XG = 1;
`else
  localparam int XG = 0;
`endif

  fetch_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
`ifdef BYTEBLAST_FETCH_SINGLE_STEP_EN
    .step      (step),
`endif
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .o_value   (o_value),
    .o_enable  (o_enable),
    .o_pc      (o_pc),
    .o_busy    (o_busy),
    .o_halted  (o_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pc;
    logic [7:0] val;
    int         gap;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mem [32];
  int         lat;
  bit         junk_en;
  bit         stale_en;
  int         total;
  int         bad;
  int         cyc;
  int         last_en;
  logic [7:0] last_val;
  int         rd_count;
  logic       prev_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] pc, input logic [7:0] val, input int gap);
    exp_t e;
    e.pc  = pc;
    e.val = val;
    e.gap = gap;
    q.push_back(e);
  endtask

  task automatic fill(input logic [7:0] w);
    for (int i = 0; i < 32; i++) mem[i] = w;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    run      = 1'b0;
    step     = 1'b0;
    stale_en = 1'b0;
    junk_en  = 1'b0;
    q.delete();
    last_val = 8'h00;
    rd_count = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_busy(input logic v, input string tag);
    int n = 0;
    while (o_busy !== v && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(o_busy), 32'(v));
  endtask

  task automatic wait_qempty(input int max, input string tag);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  // Program memory: answers each read after lat cycles; optional junk valids around the real one.
  initial begin
    int   pend = 0;
    bit   dup  = 0;
    logic [4:0] addr = '0;
    mem_valid = 1'b0;
    mem_data  = 8'hE0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      mem_data  = 8'hE0;
      if (stale_en) begin
        mem_valid = 1'b1;
        mem_data  = 8'h66;
      end else if (!rst_n) begin
        pend = 0;
        dup  = 0;
      end else begin
        if (dup) begin
          dup       = 0;
          mem_valid = 1'b1;
          mem_data  = 8'hE0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            mem_valid = 1'b1;
            mem_data  = mem[addr];
            dup       = junk_en;
          end
        end
        if (mem_rd) begin
          pend = lat;
          addr = mem_addr;
          if (junk_en) begin
            mem_valid = 1'b1;
            mem_data  = 8'hE0;
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every enable pulse, checks holding and read strobes.
  initial begin
    exp_t e;
    cyc     = 0;
    last_en = 0;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_rd = 1'b0;
      end else begin
        if (o_enable) begin
          if (q.size() == 0) begin
            chk("extra_pulse", 32'(o_pc), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("issue_value", 32'(o_value), 32'(e.val));
            chk("issue_pc", 32'(o_pc), 32'(e.pc));
            if (e.gap != 0) chk("issue_gap", 32'(cyc - last_en), 32'(e.gap));
            last_val = e.val;
          end
          last_en = cyc;
        end else begin
          chk("value_hold", 32'(o_value), 32'(last_val));
        end
        if (mem_rd) begin
          rd_count++;
          chk("rd_single", 32'(prev_rd), 32'd0);
          chk("rd_addr", 32'(mem_addr), 32'(o_pc));
        end
        prev_rd = mem_rd;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    lat   = 1;

    // Reset state and basic program ending on HALT.
    fill(8'h00);
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'h83; mem[3] = 8'hE0;
    do_reset();
    chk("rst_pc", 32'(o_pc), 32'd0);
    chk("rst_value", 32'(o_value), 32'd0);
    chk("rst_enable", 32'(o_enable), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
    push_exp(5'd0, 8'h21, 0);
    push_exp(5'd1, 8'h45, 6 + XG);
    push_exp(5'd2, 8'h83, 6 + XG);
    run = 1'b1;
    n = 0;
    while (!o_halted && n < 100) begin tick(); n++; end
    chk("t1_halted", 32'(o_halted), 32'd1);
    repeat (10) tick();
    chk("t1_halt_pc", 32'(o_pc), 32'd3);
    chk("t1_busy", 32'(o_busy), 32'd0);
    chk("t1_left", 32'(q.size()), 32'd0);
    chk("t1_reads", 32'(rd_count), 32'd4);

    // Latency 4 with junk valids in the FETCH cycle and right after the real data.
    fill(8'h00);
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'hE0;
    do_reset();
    lat     = 4;
    junk_en = 1'b1;
    push_exp(5'd0, 8'h21, 0);
    push_exp(5'd1, 8'h45, 9 + XG);
    run = 1'b1;
    n = 0;
    while (!o_halted && n < 100) begin tick(); n++; end
    chk("t2_halted", 32'(o_halted), 32'd1);
    chk("t2_halt_pc", 32'(o_pc), 32'd2);
    chk("t2_left", 32'(q.size()), 32'd0);
    chk("t2_reads", 32'(rd_count), 32'd3);

    // Drop run during WAIT of pc=1, then resume.
    fill(8'h04);
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'h83;
    do_reset();
    lat = 3;
    push_exp(5'd0, 8'h21, 0);
    push_exp(5'd1, 8'h45, 0);
    run = 1'b1;
    n = 0;
    while (!(mem_rd && mem_addr == 5'd1) && n < 100) begin tick(); n++; end
    chk("t3_rd1", 32'(mem_addr), 32'd1);
    tick();
    run = 1'b0;
    wait_busy(1'b0, "t3_idle");
    chk("t3_pc", 32'(o_pc), 32'd2);
    chk("t3_halted", 32'(o_halted), 32'd0);
    repeat (10) tick();
    chk("t3_left", 32'(q.size()), 32'd0);
    push_exp(5'd2, 8'h83, 0);
    run = 1'b1;
    n = 0;
    while (!mem_rd && n < 100) begin tick(); n++; end
    chk("t3_resume_addr", 32'(mem_addr), 32'd2);
    wait_qempty(100, "t3_resume_issue");
    run = 1'b0;
    wait_busy(1'b0, "t3_idle2");

    // 40 instructions over all-0x21 memory: wrap 31->0 without a stall.
    fill(8'h21);
    do_reset();
    lat = 1;
    for (int i = 0; i < 40; i++) push_exp(5'(i % 32), 8'h21, (i == 0) ? 0 : 6 + XG);
    run = 1'b1;
    wait_qempty(600, "t4_all_issued");
    run = 1'b0;
    wait_busy(1'b0, "t4_idle");
    chk("t4_pc", 32'(o_pc), 32'd8);

    // Asynchronous reset in SETTLE, then a stale mem_valid.
    fill(8'h00);
    mem[0] = 8'h21; mem[1] = 8'h45;
    do_reset();
    push_exp(5'd0, 8'h21, 0);
    run = 1'b1;
    wait_qempty(100, "t5_first");
    #1;
    rst_n = 1'b0;
    run   = 1'b0;
    last_val = 8'h00;
    #1;
    chk("t5_async_pc", 32'(o_pc), 32'd0);
    chk("t5_async_value", 32'(o_value), 32'd0);
    chk("t5_async_enable", 32'(o_enable), 32'd0);
    chk("t5_async_rd", 32'(mem_rd), 32'd0);
    chk("t5_async_addr", 32'(mem_addr), 32'd0);
    chk("t5_async_busy", 32'(o_busy), 32'd0);
    chk("t5_async_halted", 32'(o_halted), 32'd0);
    stale_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t5_stale_value", 32'(o_value), 32'd0);
    chk("t5_stale_busy", 32'(o_busy), 32'd0);
    stale_en = 1'b0;
    repeat (2) tick();
    push_exp(5'd0, 8'h21, 0);
    run = 1'b1;
    wait_qempty(100, "t5_restart");
    run = 1'b0;
    wait_busy(1'b0, "t5_idle");

`ifdef BYTEBLAST_FETCH_SINGLE_STEP_EN
    // Single step: three step pulses with run low.
    fill(8'h00);
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'h83;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp(5'(i), mem[i], 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_busy(1'b1, "t6_start");
      wait_busy(1'b0, "t6_idle");
      chk("t6_pc", 32'(o_pc), 32'(i + 1));
      repeat (4) tick();
      chk("t6_still_idle", 32'(o_busy), 32'd0);
    end
    chk("t6_left", 32'(q.size()), 32'd0);
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
